multiply_divide_controller: RTL and testbench
=============================================

Name: multiply_divide_controller

Overview:
- Sequences the shared multiplier and divider for the EX stage: accepts one MULT/MULTU/DIV/DIVU request at a time, launches the right unit, waits out its latency and returns a 64-bit {high, low} result.
- Drives the EX stage's ready_go, so the stage stalls until the result is captured.
- Owns the divider's valid/ready handshake and discards a flushed in-flight divide.

Parameters:
- MULTIPLY_LATENCY, 2, cycles from multiply_start to a valid multiply_product; legal range 1..15.
- DATA_WIDTH, 32, operand width; results are 2*DATA_WIDTH.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- request_valid  input  1  EX holds a valid instruction; request fields are stable until ex_ready_go
- request_is_multiply  input  1  instruction is MULT/MULTU
- request_is_divide  input  1  instruction is DIV/DIVU
- request_signed  input  1  signed operation
- request_operand_a  input  DATA_WIDTH  rs value / dividend
- request_operand_b  input  DATA_WIDTH  rt value / divisor
- downstream_accept  input  1  next stage allow_in
- flush  input  1  cancel current instruction
- ex_ready_go  output  1  EX may advance
- busy  output  1  state != IDLE
- result_valid  output  1  result_high/result_low hold a completed result
- result_high  output  DATA_WIDTH  product[63:32] or remainder
- result_low  output  DATA_WIDTH  product[31:0] or quotient
- unit_operand_a  output  DATA_WIDTH  operand to both units
- unit_operand_b  output  DATA_WIDTH  operand to both units
- unit_signed  output  1  signedness to both units
- multiply_start  output  1  launch multiplier
- multiply_product  input  2*DATA_WIDTH  multiplier output
- divide_request_valid  output  1  operands offered to divider
- divide_request_ready  input  1  divider accepts operands; transfer occurs when valid and ready are both high
- divide_result_valid  input  1  one-cycle pulse with quotient and remainder
- divide_quotient  input  DATA_WIDTH  divider quotient
- divide_remainder  input  DATA_WIDTH  divider remainder

Behaviour:
- States: IDLE, MUL_WAIT, DIV_ISSUE, DIV_WAIT, DONE, DIV_DRAIN.
- Reset:
  - Next state IDLE; counter = 0; result registers = 0.
  - All outputs 0 except ex_ready_go, which is 1 because there is no request.
  - Reset mid-operation abandons everything; the divider shares the same reset.
- Operand latch:
  - On accept, latch operand_a, operand_b and signed.
  - unit_operand_* and unit_signed come from request_* while in IDLE and from the latch otherwise.
- Accept condition: IDLE & request_valid & (request_is_multiply | request_is_divide) & !flush.
  - If both type bits are set, multiply wins.
- Multiply path:
  - On accept, multiply_start = 1 for that cycle, counter = MULTIPLY_LATENCY-1, next state MUL_WAIT.
  - In MUL_WAIT: if counter == 0, capture {result_high, result_low} = multiply_product and go to DONE; otherwise decrement.
  - Result: accept at cycle T gives DONE at T+MULTIPLY_LATENCY+1.
- Divide path:
  - On accept, go to DIV_ISSUE.
  - DIV_ISSUE: divide_request_valid = 1, held until divide_request_ready, then go to DIV_WAIT.
  - DIV_WAIT: on divide_result_valid, result_low = quotient and result_high = remainder, then go to DONE.
  - Divide-by-zero is passed to the divider unchanged; the controller adds no special case.
  - divide_result_valid in any state other than DIV_WAIT or DIV_DRAIN is ignored.
- DONE:
  - result_valid = 1, ex_ready_go = 1.
  - Stays in DONE until downstream_accept, then goes to IDLE; result registers hold their value.
  - The request seen in the cycle after leaving DONE is a new instruction.
- ex_ready_go:
  - 1 when !(request_valid & (request_is_multiply | request_is_divide)), so non-mul/div instructions pass with no stall.
  - 1 in DONE; 0 otherwise.
- Flush (highest priority, applies in every state):
  - IDLE, MUL_WAIT, DONE, or DIV_ISSUE before the handshake completes: next state IDLE, and no accept happens that cycle.
    - In DIV_ISSUE, divide_request_valid still drops next cycle.
  - DIV_ISSUE with the handshake completing in the same cycle, or DIV_WAIT: next state DIV_DRAIN.
  - DIV_DRAIN:
    - Wait for divide_result_valid, discard it, then go to IDLE.
    - No new accept while draining; ex_ready_go = 0 for pending mul/div requests.
    - divide_result_valid arriving in the flush cycle itself goes directly to IDLE.
- result_valid is cleared on leaving DONE.

Test Plan:
- Signed multiply, MULTIPLY_LATENCY=2, a=3, b=0xFFFFFFFE, bench multiplier returns product 2 cycles after start -> multiply_start pulses at T; DONE at T+3; result_high=0xFFFFFFFF, result_low=0xFFFFFFFA; ex_ready_go=0 for T..T+2.
- Unsigned divide 100/7; divider holds ready low 3 cycles and answers 5 cycles after handshake -> divide_request_valid held 4 cycles; result_low=14, result_high=2; one DONE cycle with downstream_accept=1.
- DONE with downstream_accept=0 for 4 cycles -> stays in DONE, result_valid and ex_ready_go remain 1, results stable; returns to IDLE the cycle after accept.
- Flush in DIV_WAIT, then a new multiply request is presented -> DIV_DRAIN; multiply not accepted until the stale divide_result_valid arrives; the stale quotient never appears on result_low.
- Non-mul/div request (both type bits 0) -> ex_ready_go=1 combinationally, state stays IDLE, no unit strobes.
- Reset asserted in MUL_WAIT and in DIV_ISSUE -> next cycle IDLE; divide_request_valid=0, multiply_start=0, result_valid=0, results 0.

Source files
------------

// File: rtl/multiply_divide_controller.sv
// Sequences the shared multiplier/divider for the EX stage and stalls EX via ex_ready_go
// until a {high, low} result has been captured; flushed in-flight divides are drained.
//
// state     | meaning
// IDLE      | no operation in flight, operands taken straight from the request
// MUL_WAIT  | multiplier launched, counting down its latency
// DIV_ISSUE | operands offered to the divider, waiting for ready
// DIV_WAIT  | divider owns the operation, waiting for its result pulse
// DONE      | result held, EX may advance once downstream accepts
// DIV_DRAIN | flushed divide still in the divider, its result will be dropped
module multiply_divide_controller #(
  parameter int MULTIPLY_LATENCY = 2,
  parameter int DATA_WIDTH       = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    request_valid,
  input  logic                    request_is_multiply,
  input  logic                    request_is_divide,
  input  logic                    request_signed,
  input  logic [DATA_WIDTH-1:0]   request_operand_a,
  input  logic [DATA_WIDTH-1:0]   request_operand_b,
  input  logic                    downstream_accept,
  input  logic                    flush,
  output logic                    ex_ready_go,
  output logic                    busy,
  output logic                    result_valid,
  output logic [DATA_WIDTH-1:0]   result_high,
  output logic [DATA_WIDTH-1:0]   result_low,
  output logic [DATA_WIDTH-1:0]   unit_operand_a,
  output logic [DATA_WIDTH-1:0]   unit_operand_b,
  output logic                    unit_signed,
  output logic                    multiply_start,
  input  logic [2*DATA_WIDTH-1:0] multiply_product,
  output logic                    divide_request_valid,
  input  logic                    divide_request_ready,
  input  logic                    divide_result_valid,
  input  logic [DATA_WIDTH-1:0]   divide_quotient,
  input  logic [DATA_WIDTH-1:0]   divide_remainder
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MUL_WAIT  = 3'd1,
    DIV_ISSUE = 3'd2,
    DIV_WAIT  = 3'd3,
    DONE      = 3'd4,
    DIV_DRAIN = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              count_q, count_d;
  logic [DATA_WIDTH-1:0]   result_high_q, result_high_d;
  logic [DATA_WIDTH-1:0]   result_low_q, result_low_d;
  logic [DATA_WIDTH-1:0]   operand_a_q, operand_a_d;
  logic [DATA_WIDTH-1:0]   operand_b_q, operand_b_d;
  logic                    signed_q, signed_d;
  logic                    muldiv_request;

  assign muldiv_request = request_valid & (request_is_multiply | request_is_divide);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      count_q       <= '0;
      result_high_q <= '0;
      result_low_q  <= '0;
      operand_a_q   <= '0;
      operand_b_q   <= '0;
      signed_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      result_high_q <= result_high_d;
      result_low_q  <= result_low_d;
      operand_a_q   <= operand_a_d;
      operand_b_q   <= operand_b_d;
      signed_q      <= signed_d;
    end
  end

  always_comb begin
    state_d              = state_q;
    count_d              = count_q;
    result_high_d        = result_high_q;
    result_low_d         = result_low_q;
    operand_a_d          = operand_a_q;
    operand_b_d          = operand_b_q;
    signed_d             = signed_q;
    multiply_start       = 1'b0;
    divide_request_valid = 1'b0;

    case (state_q)
      IDLE: begin
        if (muldiv_request && !flush && !reset) begin
          operand_a_d = request_operand_a;
          operand_b_d = request_operand_b;
          signed_d    = request_signed;
          // multiply wins when both type bits are set
          if (request_is_multiply) begin
            multiply_start = 1'b1;
            count_d        = 4'(MULTIPLY_LATENCY - 1);
            state_d        = MUL_WAIT;
          end else begin
            state_d = DIV_ISSUE;
          end
        end
      end
      MUL_WAIT: begin
        if (flush) begin
          state_d = IDLE;
        end else if (count_q == 4'd0) begin
          {result_high_d, result_low_d} = multiply_product;
          state_d = DONE;
        end else begin
          count_d = count_q - 4'd1;
        end
      end
      DIV_ISSUE: begin
        divide_request_valid = 1'b1;
        // once the divider has the operands a flush must wait for its answer
        if (divide_request_ready) begin
          state_d = flush ? DIV_DRAIN : DIV_WAIT;
        end else if (flush) begin
          state_d = IDLE;
        end
      end
      DIV_WAIT: begin
        if (divide_result_valid) begin
          if (!flush) begin
            result_low_d  = divide_quotient;
            result_high_d = divide_remainder;
            state_d       = DONE;
          end else begin
            state_d = IDLE;
          end
        end else if (flush) begin
          state_d = DIV_DRAIN;
        end
      end
      DONE: begin
        if (flush || downstream_accept) begin
          state_d = IDLE;
        end
      end
      DIV_DRAIN: begin
        if (divide_result_valid) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy           = (state_q != IDLE);
  assign result_valid   = (state_q == DONE);
  assign ex_ready_go    = (state_q == DONE) | !muldiv_request;
  assign result_high    = result_high_q;
  assign result_low     = result_low_q;
  assign unit_operand_a = (state_q == IDLE) ? request_operand_a : operand_a_q;
  assign unit_operand_b = (state_q == IDLE) ? request_operand_b : operand_b_q;
  assign unit_signed    = (state_q == IDLE) ? request_signed : signed_q;

endmodule

// File: tb/tb_multiply_divide_controller.sv
// Bench for multiply_divide_controller: bench-side multiplier/divider, a transaction-level
// reference model compared every cycle, and directed scenarios with literal expectations.
module tb_multiply_divide_controller;
  localparam int LAT = 2;
  localparam int DW  = 32;

  logic          clock, reset;
  logic          request_valid, request_is_multiply, request_is_divide, request_signed;
  logic [DW-1:0] request_operand_a, request_operand_b;
  logic          downstream_accept, flush;
  logic          ex_ready_go, busy, result_valid;
  logic [DW-1:0] result_high, result_low, unit_operand_a, unit_operand_b;
  logic          unit_signed, multiply_start;
  logic [2*DW-1:0] multiply_product;
  logic          divide_request_valid, divide_request_ready, divide_result_valid;
  logic [DW-1:0] divide_quotient, divide_remainder;

  multiply_divide_controller #(.MULTIPLY_LATENCY(LAT), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset),
    .request_valid(request_valid), .request_is_multiply(request_is_multiply),
    .request_is_divide(request_is_divide), .request_signed(request_signed),
    .request_operand_a(request_operand_a), .request_operand_b(request_operand_b),
    .downstream_accept(downstream_accept), .flush(flush),
    .ex_ready_go(ex_ready_go), .busy(busy), .result_valid(result_valid),
    .result_high(result_high), .result_low(result_low),
    .unit_operand_a(unit_operand_a), .unit_operand_b(unit_operand_b),
    .unit_signed(unit_signed), .multiply_start(multiply_start),
    .multiply_product(multiply_product),
    .divide_request_valid(divide_request_valid), .divide_request_ready(divide_request_ready),
    .divide_result_valid(divide_result_valid),
    .divide_quotient(divide_quotient), .divide_remainder(divide_remainder)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting at %0t", nm, $time);
  endtask

  function automatic logic [63:0] mul_ref(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [63:0] ea, eb;
    ea = s ? {{32{a[31]}}, a} : {32'd0, a};
    eb = s ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  // returns {remainder, quotient}; division by zero answered with all-ones / dividend
  function automatic logic [63:0] div_ref(input logic [31:0] a, input logic [31:0] b, input logic s);
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
    return {a % b, a / b};
  endfunction

  // bench-side units and their knobs
  int rdelay = 0;
  int dlat   = 1;
  int vcnt   = 0;
  int div_left = 0;
  logic spur = 1'b0;
  logic [2*DW-1:0] pipe [1:LAT];
  int cyc = 0;

  assign divide_request_ready = (vcnt >= rdelay);
  assign divide_result_valid  = (div_left == 1) || spur;
  assign multiply_product     = pipe[LAT];

  // reference model: what operation is in flight and what the result must be
  logic m_mul = 0, m_offer = 0, m_wait = 0, m_drain = 0, m_done = 0;
  int   m_left = 0;
  logic [31:0] m_opa = 0, m_opb = 0, m_hi = 0, m_lo = 0;
  logic m_sgn = 0;
  logic cmp_en = 0;

  function automatic logic m_idle();
    return !(m_mul || m_offer || m_wait || m_drain || m_done);
  endfunction

  always @(posedge clock) begin
    logic [63:0] r;
    cyc++;
    if (reset) begin
      m_mul = 0; m_offer = 0; m_wait = 0; m_drain = 0; m_done = 0;
      m_hi = 0; m_lo = 0; m_left = 0;
    end else if (m_idle()) begin
      if (request_valid && (request_is_multiply || request_is_divide) && !flush) begin
        m_opa = request_operand_a; m_opb = request_operand_b; m_sgn = request_signed;
        if (request_is_multiply) begin m_mul = 1; m_left = LAT; end
        else m_offer = 1;
      end
    end else if (m_mul) begin
      if (flush) m_mul = 0;
      else begin
        m_left--;
        if (m_left == 0) begin
          r = mul_ref(m_opa, m_opb, m_sgn);
          m_hi = r[63:32]; m_lo = r[31:0];
          m_mul = 0; m_done = 1;
        end
      end
    end else if (m_offer) begin
      if (flush) begin m_offer = 0; m_drain = divide_request_ready; end
      else if (divide_request_ready) begin m_offer = 0; m_wait = 1; end
    end else if (m_wait) begin
      if (divide_result_valid) begin
        m_wait = 0;
        if (!flush) begin
          r = div_ref(m_opa, m_opb, m_sgn);
          m_hi = r[63:32]; m_lo = r[31:0]; m_done = 1;
        end
      end else if (flush) begin
        m_wait = 0; m_drain = 1;
      end
    end else if (m_drain) begin
      if (divide_result_valid) m_drain = 0;
    end else if (m_done) begin
      if (flush || downstream_accept) m_done = 0;
    end

    if (reset) begin
      vcnt = 0; div_left = 0;
    end else begin
      if (div_left != 0) div_left--;
      if (divide_request_valid && divide_request_ready) begin
        r = div_ref(unit_operand_a, unit_operand_b, unit_signed);
        divide_remainder = r[63:32]; divide_quotient = r[31:0];
        div_left = dlat; vcnt = 0;
      end else if (divide_request_valid) vcnt++;
      else vcnt = 0;
    end

    for (int k = LAT; k > 1; k--) pipe[k] = pipe[k-1];
    pipe[1] = multiply_start ? mul_ref(unit_operand_a, unit_operand_b, unit_signed)
                             : (64'hBAD0_BAD0_BAD0_BAD0 ^ 64'(cyc));
  end

  always @(negedge clock) begin
    logic idle, req;
    if (cmp_en) begin
      idle = m_idle();
      req  = request_valid && (request_is_multiply || request_is_divide);
      chk("busy", busy, !idle);
      chk("result_valid", result_valid, m_done);
      chk("ex_ready_go", ex_ready_go, m_done || !req);
      chk("multiply_start", multiply_start, idle && req && request_is_multiply && !flush && !reset);
      chk("divide_request_valid", divide_request_valid, m_offer);
      chk("unit_operand_a", unit_operand_a, idle ? request_operand_a : m_opa);
      chk("unit_operand_b", unit_operand_b, idle ? request_operand_b : m_opb);
      chk("unit_signed", unit_signed, idle ? request_signed : m_sgn);
      chk("result_high", result_high, m_hi);
      chk("result_low", result_low, m_lo);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input logic m, input logic d, input logic s,
                         input logic [31:0] a, input logic [31:0] b);
    request_valid = 1; request_is_multiply = m; request_is_divide = d;
    request_signed = s; request_operand_a = a; request_operand_b = b;
  endtask

  // called at a negedge; returns cycles until result_valid plus valid/stall counts
  task automatic wait_done(input string nm, output int n, output int ndv, output int nst);
    n = 0; ndv = 0; nst = 0;
    while (1) begin
      ndv += int'(divide_request_valid);
      nst += int'(!ex_ready_go);
      if (result_valid) break;
      if (n >= 60) begin timeout(nm); break; end
      @(posedge clock); @(negedge clock);
      n++;
    end
  endtask

  task automatic finish_op(input string nm);
    tick();
    request_valid = 0;
    @(negedge clock);
    chk(nm, busy, 0);
  endtask

  int n, ndv, nst;

  initial begin
    reset = 1; flush = 0; downstream_accept = 1;
    request_valid = 0; request_is_multiply = 0; request_is_divide = 0; request_signed = 0;
    request_operand_a = 0; request_operand_b = 0;
    divide_quotient = 0; divide_remainder = 0;
    for (int k = 1; k <= LAT; k++) pipe[k] = '0;
    repeat (3) tick();
    reset = 0;
    cmp_en = 1;
    @(negedge clock);
    chk("reset_busy", busy, 0);
    chk("reset_ready_go", ex_ready_go, 1);
    chk("reset_result", {result_high, result_low}, 64'd0);

    // signed multiply 3 * -2
    tick();
    set_req(1, 0, 1, 32'd3, 32'hFFFF_FFFE);
    @(negedge clock);
    chk("mul_start_pulse", multiply_start, 1);
    wait_done("mul_done", n, ndv, nst);
    chk("mul_done_cycle", n, 3);
    chk("mul_stall_cycles", nst, 3);
    chk("mul_high", result_high, 32'hFFFF_FFFF);
    chk("mul_low", result_low, 32'hFFFF_FFFA);
    finish_op("mul_idle_after");

    // unsigned divide 100 / 7, ready late by 3, answer 5 after handshake
    tick();
    rdelay = 3; dlat = 5;
    set_req(0, 1, 0, 32'd100, 32'd7);
    @(negedge clock);
    wait_done("div_done", n, ndv, nst);
    chk("div_done_cycle", n, 10);
    chk("div_valid_cycles", ndv, 4);
    chk("div_quotient", result_low, 32'd14);
    chk("div_remainder", result_high, 32'd2);
    finish_op("div_single_done");

    // DONE held while downstream stalls
    tick();
    downstream_accept = 0;
    set_req(1, 0, 0, 32'h0001_0000, 32'h0001_0000);
    @(negedge clock);
    wait_done("hold_done", n, ndv, nst);
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clock);
      chk("hold_result_valid", result_valid, 1);
      chk("hold_ready_go", ex_ready_go, 1);
      chk("hold_result", {result_high, result_low}, 64'h0000_0001_0000_0000);
    end
    tick();
    downstream_accept = 1; request_valid = 0;
    @(negedge clock);
    chk("hold_accept_cycle", result_valid, 1);
    tick();
    @(negedge clock);
    chk("hold_idle_busy", busy, 0);
    chk("hold_results_kept", result_high, 32'd1);

    // flush in DIV_WAIT, multiply waits for the stale divide result
    tick();
    rdelay = 0; dlat = 6;
    set_req(0, 1, 1, 32'hFFFF_FF9C, 32'd7);
    tick(); tick(); tick();
    flush = 1;
    set_req(1, 0, 0, 32'd5, 32'd6);
    tick();
    flush = 0;
    n = 0;
    @(negedge clock);
    while (!multiply_start && n < 30) begin
      @(posedge clock); @(negedge clock);
      n++;
    end
    chk("drain_mul_accept_delay", n, 4);
    wait_done("drain_mul_done", n, ndv, nst);
    chk("drain_mul_low", result_low, 32'd30);
    chk("drain_mul_high", result_high, 32'd0);
    finish_op("drain_idle_after");

    // non-mul/div instruction, stray divider pulse, flush blocks an accept
    tick();
    set_req(0, 0, 0, 32'd9, 32'd9);
    spur = 1;
    @(negedge clock);
    chk("plain_ready_go", ex_ready_go, 1);
    chk("plain_mul_start", multiply_start, 0);
    chk("plain_div_valid", divide_request_valid, 0);
    tick();
    spur = 0;
    @(negedge clock);
    chk("stray_pulse_busy", busy, 0);
    chk("stray_pulse_low", result_low, 32'd30);
    tick();
    set_req(1, 0, 0, 32'd2, 32'd2);
    flush = 1;
    @(negedge clock);
    chk("flush_blocks_start", multiply_start, 0);
    tick();
    flush = 0; request_valid = 0;
    @(negedge clock);
    chk("flush_blocks_busy", busy, 0);

    // reset in MUL_WAIT
    tick();
    set_req(1, 0, 1, 32'd7, 32'd7);
    tick();
    reset = 1; request_valid = 0;
    tick();
    reset = 0;
    @(negedge clock);
    chk("rst_mul_busy", busy, 0);
    chk("rst_mul_start", multiply_start, 0);
    chk("rst_mul_result_valid", result_valid, 0);
    chk("rst_mul_results", {result_high, result_low}, 64'd0);

    // reset in DIV_ISSUE
    tick();
    rdelay = 10;
    set_req(0, 1, 0, 32'd40, 32'd3);
    tick();
    @(negedge clock);
    chk("rst_div_offering", divide_request_valid, 1);
    tick();
    reset = 1; request_valid = 0;
    tick();
    reset = 0;
    @(negedge clock);
    chk("rst_div_valid", divide_request_valid, 0);
    chk("rst_div_busy", busy, 0);

    // flush on the handshake cycle drains the divide
    tick();
    rdelay = 0; dlat = 3;
    set_req(0, 1, 0, 32'd50, 32'd5);
    tick();
    flush = 1;
    tick();
    flush = 0; request_valid = 0;
    n = 0;
    @(negedge clock);
    while (busy && n < 20) begin
      @(posedge clock); @(negedge clock);
      n++;
    end
    chk("hs_flush_drain_cycles", n, 3);
    chk("hs_flush_low", result_low, 32'd0);

    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
